// File: rtl/seg_page_sched_pkg.sv
// Shared constants, converter state encoding and helpers for the paged
// seven-segment value scheduler.
package seg_pkg;

  localparam int BCD_DIGITS = 6;
  localparam int DATA_W     = 20;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int NUM_PAGES  = 3;

  localparam logic [DATA_W-1:0] BCD_MAX     = 20'd999_999;
  localparam logic [3:0]        DIGIT_OVF   = 4'hF;
  localparam logic [4:0]        SHIFT_COUNT = 5'd20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // First enabled page after cur, cyclic; cur itself when nothing else is enabled.
  function automatic logic [1:0] next_page(input logic [1:0] cur,
                                           input logic [NUM_PAGES-1:0] en);
    logic [1:0] res;
    logic [1:0] cand;
    logic       found;
    res   = cur;
    cand  = cur;
    found = 1'b0;
    for (int k = 0; k < NUM_PAGES; k++) begin
      cand = (cand >= 2'd2) ? 2'd0 : cand + 2'd1;
      if (!found && en[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_page_sched_if.sv
// Source/enable inputs and digit outputs of the page scheduler, grouped as
// one bundle; the scheduler sits on the slave side.
interface seg_page_sched_if;
  import seg_pkg::*;

  logic [DATA_W-1:0]    src0_data;
  logic [DATA_W-1:0]    src1_data;
  logic [DATA_W-1:0]    src2_data;
  logic [NUM_PAGES-1:0] src_en;
  logic                 freeze;
  logic [1:0]           page;
  logic                 conv_busy;
  logic                 upd;
  logic [3:0]           d0;
  logic [3:0]           d1;
  logic [3:0]           d2;
  logic [3:0]           d3;
  logic [3:0]           d4;
  logic [3:0]           d5;

  modport master (
    output src0_data, src1_data, src2_data, src_en, freeze,
    input  page, conv_busy, upd, d0, d1, d2, d3, d4, d5
  );

  modport slave (
    input  src0_data, src1_data, src2_data, src_en, freeze,
    output page, conv_busy, upd, d0, d1, d2, d3, d4, d5
  );

endinterface

// File: rtl/seg_page_sched_bin2bcd_seq.sv
// Sequential 20-bit binary to six-digit BCD converter (shift-add-3).
// Result and overflow flag change together, only when entering DONE.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [BCD_W-1:0]  bcd
);

  conv_state_t state, state_next;

  logic [DATA_W-1:0]       bin_q;
  logic [BCD_W-1:0]        acc_q;
  logic [4:0]              shift_cnt;
  logic                    snap_ovf;
  logic [BCD_W-1:0]        result_q;
  logic                    result_ovf;
  logic [BCD_W-1:0]        acc_adj;
  logic [BCD_W+DATA_W-1:0] shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (shift_cnt == 5'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign acc_adj = bcd_add3(acc_q);
  assign shifted = {acc_adj, bin_q} << 1;

  // The last shift writes straight into the result register so DONE already shows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      acc_q      <= '0;
      shift_cnt  <= '0;
      snap_ovf   <= 1'b0;
      result_q   <= '0;
      result_ovf <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          bin_q     <= value;
          acc_q     <= '0;
          shift_cnt <= SHIFT_COUNT;
          snap_ovf  <= (value > BCD_MAX);
        end
        SHIFT: begin
          acc_q     <= shifted[BCD_W+DATA_W-1:DATA_W];
          bin_q     <= shifted[DATA_W-1:0];
          shift_cnt <= shift_cnt - 5'd1;
          if (shift_cnt == 5'd1) begin
            result_q   <= shifted[BCD_W+DATA_W-1:DATA_W];
            result_ovf <= snap_ovf;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign ovf  = result_ovf;
  assign bcd  = result_q;

endmodule

// File: rtl/seg_page_sched.sv
// Round-robin page scheduler: periodic refresh tick, page dwell/arbitration,
// one-deep pending request and BCD digit outputs for the 6-digit display.
module seg_page_sched
  import seg_pkg::*;
#(
  parameter logic [22:0] REFRESH_MAX    = 23'd4_999_999,
  parameter logic [3:0]  PAGE_REFRESHES = 4'd9
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_page_sched_if.slave bus
);

  logic [22:0]       refresh_cnt;
  logic              tick;
  logic [3:0]        dwell_cnt;
  logic [1:0]        page_q;
  logic              pending_q;
  logic              start;
  logic [DATA_W-1:0] sel_value;
  logic              conv_busy;
  logic              conv_done;
  logic              conv_ovf;
  logic [BCD_W-1:0]  conv_bcd;
  logic [3:0]        digits [BCD_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
    end else if (refresh_cnt == REFRESH_MAX) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 23'd1;
    end
  end

  assign tick = (refresh_cnt == REFRESH_MAX);

  // A disabled current page is left at once, ignoring dwell and freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q    <= '0;
      dwell_cnt <= '0;
    end else if (tick) begin
      if (!bus.src_en[page_q]) begin
        page_q    <= next_page(page_q, bus.src_en);
        dwell_cnt <= '0;
      end else if (dwell_cnt == PAGE_REFRESHES) begin
        dwell_cnt <= '0;
        if (!bus.freeze) begin
          page_q <= next_page(page_q, bus.src_en);
        end
      end else begin
        dwell_cnt <= dwell_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if (tick && conv_busy) begin
      pending_q <= 1'b1;
    end else if (!conv_busy) begin
      pending_q <= 1'b0;
    end
  end

  assign start = tick | pending_q;

  // The converter samples this in LOAD, when page_q already holds the new page.
  always_comb begin
    sel_value = bus.src2_data;
    case (page_q)
      2'd0:    sel_value = bus.src0_data;
      2'd1:    sel_value = bus.src1_data;
      default: sel_value = bus.src2_data;
    endcase
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (sel_value),
    .busy  (conv_busy),
    .done  (conv_done),
    .ovf   (conv_ovf),
    .bcd   (conv_bcd)
  );

  always_comb begin
    for (int i = 0; i < BCD_DIGITS; i++) begin
      digits[i] = conv_ovf ? DIGIT_OVF : conv_bcd[4*i +: 4];
    end
  end

  assign bus.page      = page_q;
  assign bus.conv_busy = conv_busy;
  assign bus.upd       = conv_done;
  assign bus.d0        = digits[0];
  assign bus.d1        = digits[1];
  assign bus.d2        = digits[2];
  assign bus.d3        = digits[3];
  assign bus.d4        = digits[4];
  assign bus.d5        = digits[5];

endmodule
